// File: rtl/resonator_ctrl.sv
// Run sequencer for the resonator/sigma-delta datapath: programs the coefficient,
// waits a settle window, then packs the 1-bit stream MSB-first into 32-bit words.
module resonator_ctrl #(
  parameter int CNT_W = 32,
  parameter int NW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_coef,
  input  logic [CNT_W-1:0] cfg_settle,
  input  logic [NW_W-1:0]  cfg_nwords,
  output logic             res_en,
  output logic [31:0]      res_coef,
  output logic             res_coef_ld,
  input  logic             res_bit,
  output logic [31:0]      word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [NW_W-1:0]  nwords_q;
  logic [NW_W-1:0]  word_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      shreg;

  // Sequencer state, counters, capture shift register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= {CNT_W{1'b0}};
      nwords_q    <= {NW_W{1'b0}};
      word_cnt    <= {NW_W{1'b0}};
      bit_cnt     <= 5'd0;
      shreg       <= 32'd0;
      res_en      <= 1'b0;
      res_coef    <= 32'd0;
      res_coef_ld <= 1'b0;
      word_data   <= 32'd0;
      word_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      res_coef_ld <= 1'b0;
      done        <= 1'b0;
      // A transfer frees the output register; a word loading this cycle overrides below.
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if ((state != IDLE) && abort) begin
        state      <= IDLE;
        res_en     <= 1'b0;
        word_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= LOAD;
              res_coef   <= cfg_coef;
              settle_cnt <= cfg_settle;
              nwords_q   <= cfg_nwords;
              word_cnt   <= {NW_W{1'b0}};
              bit_cnt    <= 5'd0;
              shreg      <= 32'd0;
              ovf        <= 1'b0;
              busy       <= 1'b1;
              res_coef_ld <= 1'b1;
            end
          end
          LOAD: begin
            if (settle_cnt != {CNT_W{1'b0}}) begin
              state  <= SETTLE;
              res_en <= 1'b1;
            end else if (nwords_q == {NW_W{1'b0}}) begin
              state  <= DRAIN;
            end else begin
              state  <= CAPTURE;
              res_en <= 1'b1;
            end
          end
          SETTLE: begin
            if (settle_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              if (nwords_q == {NW_W{1'b0}}) begin
                state  <= DRAIN;
                res_en <= 1'b0;
              end else begin
                state  <= CAPTURE;
              end
            end
            settle_cnt <= settle_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
          CAPTURE: begin
            shreg   <= {shreg[30:0], res_bit};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              word_cnt <= word_cnt + {{(NW_W-1){1'b0}}, 1'b1};
              if (!word_valid || word_ready) begin
                word_data  <= {shreg[30:0], res_bit};
                word_valid <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
              if (word_cnt == (nwords_q - {{(NW_W-1){1'b0}}, 1'b1})) begin
                state  <= DRAIN;
                res_en <= 1'b0;
              end
            end
          end
          DRAIN: begin
            if (!word_valid || word_ready) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            res_en     <= 1'b0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_resonator_ctrl.sv
// Scoreboard bench for resonator_ctrl: expected words are queued when a run is
// launched and compared as transfers happen; cycle numbers count from the start edge.
module tb_resonator_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] cfg_coef;
  logic [31:0] cfg_settle;
  logic [15:0] cfg_nwords;
  logic        res_en;
  logic [31:0] res_coef;
  logic        res_coef_ld;
  logic        res_bit;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;
  logic        ovf;

  resonator_ctrl #(.CNT_W(32), .NW_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_coef(cfg_coef), .cfg_settle(cfg_settle), .cfg_nwords(cfg_nwords),
    .res_en(res_en), .res_coef(res_coef), .res_coef_ld(res_coef_ld),
    .res_bit(res_bit), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int          base = 0;
  int          cur_s = 0;
  bit          stream [0:127];
  logic [31:0] sbq [$];
  int          xfer_cyc [$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit sampled at the edge ending cycle 2+S+i is stream[i].
  always @(negedge clk) begin
    int idx;
    idx = (tick - base) - (2 + cur_s);
    if (idx >= 0 && idx < 128) res_bit = stream[idx];
    else res_bit = 1'b0;
  end

  // Transfer monitor: pops the scoreboard on every valid & ready edge.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = tick - base;
    end
    if (word_valid && word_ready) begin
      if (sbq.size() == 0) check("unexpected_word", word_data, 32'hxxxx_xxxx);
      else check("word", word_data, sbq.pop_front());
      xfer_cyc.push_back(tick - base);
    end
  end

  task automatic fill_stream(input bit alt);
    for (int i = 0; i < 128; i++) begin
      if (alt) stream[i] = (i % 2 == 0);
      else stream[i] = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic push_words(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      logic [31:0] w;
      for (int j = 0; j < 32; j++) w[31-j] = stream[32*k + j];
      sbq.push_back(w);
    end
  endtask

  task automatic start_run(input logic [31:0] coef, input int s, input int n);
    @(negedge clk);
    cfg_coef = coef; cfg_settle = s; cfg_nwords = 16'(n); cur_s = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = tick - 1;
    xfer_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic to_cycle(input int c);
    while ((tick - base) < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int limit);
    int w = 0;
    while (done_cnt == 0 && w < limit) begin
      @(posedge clk); #1;
      w++;
    end
    check("done_timeout", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  function automatic int xc(input int i);
    return (xfer_cyc.size() > i) ? xfer_cyc[i] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    cfg_coef = 32'd0; cfg_settle = 32'd0; cfg_nwords = 16'd0;
    fill_stream(1'b1);
    #12;
    check("rst_flags", {26'd0, res_en, res_coef_ld, word_valid, busy, done, ovf}, 32'd0);
    check("rst_coef", res_coef, 32'd0);
    check("rst_data", word_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    // abort beats start in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("abort_beats_start", 32'(busy), 32'd0);

    // 1: settle 10, two words of 1010..., ready held high
    fill_stream(1'b1); push_words(2); word_ready = 1'b1;
    start_run(32'h1234_5678, 10, 2);
    check("t1_coef_ld", 32'(res_coef_ld), 32'd1);
    check("t1_coef", res_coef, 32'h1234_5678);
    check("t1_en_c1", 32'(res_en), 32'd0);
    to_cycle(2);
    check("t1_en_c2", 32'(res_en), 32'd1);
    check("t1_ld_c2", 32'(res_coef_ld), 32'd0);
    to_cycle(75);
    check("t1_en_c75", 32'(res_en), 32'd1);
    to_cycle(76);
    check("t1_en_c76", 32'(res_en), 32'd0);
    wait_done(50);
    check("t1_w0_cyc", 32'(xc(0)), 32'd44);
    check("t1_w1_cyc", 32'(xc(1)), 32'd76);
    check("t1_done_cyc", 32'(done_cyc), 32'd77);
    to_cycle(80);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_done_once", 32'(done_cnt), 32'd1);
    check("t1_ovf", 32'(ovf), 32'd0);

    // 2: three words, ready low -> word 0 held, 1 and 2 dropped, stuck in DRAIN
    fill_stream(1'b0); push_words(1); word_ready = 1'b0;
    start_run(32'hCAFE_0002, 0, 3);
    to_cycle(120);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ovf", 32'(ovf), 32'd1);
    check("t2_valid", 32'(word_valid), 32'd1);
    check("t2_no_done", 32'(done_cnt), 32'd0);
    word_ready = 1'b1;
    wait_done(10);
    check("t2_xfers", 32'(xfer_cyc.size()), 32'd1);
    check("t2_ovf_sticky", 32'(ovf), 32'd1);

    // 3: word 1 completes on the same edge word 0 transfers -> no drop
    fill_stream(1'b0); push_words(2); word_ready = 1'b0;
    start_run(32'hCAFE_0003, 0, 2);
    check("t3_ovf_cleared", 32'(ovf), 32'd0);
    to_cycle(65);
    word_ready = 1'b1;
    to_cycle(66);
    check("t3_valid_c66", 32'(word_valid), 32'd1);
    check("t3_ovf", 32'(ovf), 32'd0);
    wait_done(10);
    check("t3_w0_cyc", 32'(xc(0)), 32'd65);
    check("t3_w1_cyc", 32'(xc(1)), 32'd66);

    // 4: settle 0, nwords 0 -> LOAD, DRAIN, DONE
    start_run(32'hCAFE_0004, 0, 0);
    check("t4_coef_ld", 32'(res_coef_ld), 32'd1);
    wait_done(20);
    check("t4_done_cyc", 32'(done_cyc), 32'd3);
    check("t4_no_word", 32'(xfer_cyc.size()), 32'd0);

    // 5a: abort during SETTLE
    word_ready = 1'b0;
    start_run(32'hCAFE_0005, 20, 1);
    to_cycle(8);
    do_abort();
    check("t5a_state", {29'd0, busy, res_en, word_valid}, 32'd0);
    to_cycle(60);
    check("t5a_no_done", 32'(done_cnt), 32'd0);

    // 5b: abort in CAPTURE while a word is pending (discarded, not pushed)
    fill_stream(1'b0);
    start_run(32'hCAFE_0006, 0, 3);
    to_cycle(40);
    check("t5b_pending", 32'(word_valid), 32'd1);
    do_abort();
    check("t5b_state", {29'd0, busy, res_en, word_valid}, 32'd0);
    to_cycle(60);
    check("t5b_no_done", 32'(done_cnt), 32'd0);

    // 5c: fresh run after abort
    fill_stream(1'b0); push_words(1); word_ready = 1'b1;
    start_run(32'hCAFE_0007, 3, 1);
    wait_done(100);
    check("t5c_w0_cyc", 32'(xc(0)), 32'd37);

    // 6: asynchronous reset mid-CAPTURE, then a normal run
    fill_stream(1'b0); push_words(1); word_ready = 1'b1;
    start_run(32'hCAFE_0008, 0, 2);
    to_cycle(40);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_flags", {26'd0, res_en, res_coef_ld, word_valid, busy, done, ovf}, 32'd0);
    check("t6_rst_data", word_data, 32'd0);
    check("t6_rst_coef", res_coef, 32'd0);
    #3 rst = 1'b0;
    fill_stream(1'b0); push_words(1);
    start_run(32'hCAFE_0009, 1, 1);
    check("t6_restart_busy", 32'(busy), 32'd1);
    wait_done(100);
    check("t6_w0_cyc", 32'(xc(0)), 32'd35);

    check("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
